// File: rtl/pfd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pfd_pkg
// Description : Shared types, default widths/gains and saturation helpers for
//               the PFD loop controller.
// Revision    : 1.0
// ============================================================================
package pfd_pkg;

    // Signed phase error: -1 (down), 0, +1 (up)
    typedef logic signed [1:0] err_t;

    localparam err_t c_err_up   = 2'sb01;
    localparam err_t c_err_dn   = 2'sb11;
    localparam err_t c_err_zero = 2'sb00;

    localparam int c_fcw_w       = 16;
    localparam int c_acc_w       = 16;
    localparam int c_int_w       = 16;
    localparam int c_nom_fcw     = 4096;
    localparam int c_kp          = 64;
    localparam int c_ki          = 1;
    localparam int c_lock_tol    = 2;
    localparam int c_lock_cycles = 8;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Clamp a signed value into the two's-complement range of a w-bit word.
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] x,
                                                 input int                 w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

    // Clamp a signed value into the unsigned range [0, 2^w-1].
    function automatic logic signed [63:0] clamp_u(input logic signed [63:0] x,
                                                   input int                 w);
        logic signed [63:0] hi;
        hi = (64'sd1 <<< w) - 64'sd1;
        if (x > hi)
            return hi;
        else if (x < 64'sd0)
            return 64'sd0;
        else
            return x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pfd_loop_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pfd_loop_ctrl_if
// Description : PFD pulse inputs, hold control and DCO/lock outputs.
// Revision    : 1.0
// ============================================================================
interface pfd_loop_ctrl_if #(
    parameter int FCW_W = 16
) ();
    logic             qa;
    logic             qb;
    logic             freeze;
    logic             clk_out;
    logic [FCW_W-1:0] fcw;
    logic             locked;

    modport master (
        output qa,
        output qb,
        output freeze,
        input  clk_out,
        input  fcw,
        input  locked
    );

    modport slave (
        input  qa,
        input  qb,
        input  freeze,
        output clk_out,
        output fcw,
        output locked
    );
endinterface
`default_nettype wire

// File: rtl/pfd_dco.sv
`default_nettype none
// ============================================================================
// Module      : pfd_dco
// Description : Phase-accumulator DCO; clk_out is the registered accumulator MSB.
// Revision    : 1.0
// ============================================================================
module pfd_dco #(
    parameter int FCW_W = 16,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [FCW_W-1:0] fcw,
    output logic             acc_msb,
    output logic             clk_out
);
    logic [ACC_W-1:0] r_acc;
    logic             r_clk_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_clk_out <= 1'b0;
        end else begin
            // Modular wrap is the intended oscillation mechanism
            r_acc     <= r_acc + ACC_W'(fcw);
            r_clk_out <= r_acc[ACC_W-1];
        end
    end

    assign acc_msb = r_acc[ACC_W-1];
    assign clk_out = r_clk_out;
endmodule
`default_nettype wire

// File: rtl/pfd_loop_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pfd_loop_ctrl
// Description : PFD-driven PI loop filter, DCO and lock detector.
// Revision    : 1.0
// ============================================================================
module pfd_loop_ctrl
    import pfd_pkg::*;
#(
    parameter int FCW_W       = c_fcw_w,
    parameter int ACC_W       = c_acc_w,
    parameter int INT_W       = c_int_w,
    parameter int NOM_FCW     = c_nom_fcw,
    parameter int KP          = c_kp,
    parameter int KI          = c_ki,
    parameter int LOCK_TOL    = c_lock_tol,
    parameter int LOCK_CYCLES = c_lock_cycles
) (
    input  logic            clk,
    input  logic            rst,
    pfd_loop_ctrl_if.slave  bus
);
    localparam int c_sum_w  = max_i(FCW_W, INT_W) + 2;
    localparam int c_wcnt_w = $clog2(LOCK_TOL + 2);
    localparam int c_lcnt_w = $clog2(LOCK_CYCLES + 1);

    localparam logic [c_wcnt_w-1:0] c_wmax = c_wcnt_w'(LOCK_TOL + 1);
    localparam logic [c_lcnt_w-1:0] c_lmax = c_lcnt_w'(LOCK_CYCLES);

    // Two-flop synchronisers for the asynchronous PFD pulses
    logic r_qa_m, r_qa_s;
    logic r_qb_m, r_qb_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_qa_m <= 1'b0;
            r_qa_s <= 1'b0;
            r_qb_m <= 1'b0;
            r_qb_s <= 1'b0;
        end else begin
            r_qa_m <= bus.qa;
            r_qa_s <= r_qa_m;
            r_qb_m <= bus.qb;
            r_qb_s <= r_qb_m;
        end
    end

    err_t w_err;

    always_comb begin
        w_err = c_err_zero;
        case ({r_qa_s, r_qb_s})
            2'b10:   w_err = c_err_up;
            2'b01:   w_err = c_err_dn;
            default: w_err = c_err_zero;
        endcase
    end

    // PI filter
    logic signed [INT_W-1:0]   r_integ;
    logic signed [63:0]        w_integ_wide;
    logic signed [INT_W-1:0]   w_integ_sat;
    logic signed [INT_W-1:0]   w_integ_next;
    logic signed [c_sum_w-1:0] w_fcw_sum;
    logic        [FCW_W-1:0]   w_fcw_next;
    logic        [FCW_W-1:0]   r_fcw;

    always_comb begin
        w_integ_wide = 64'(r_integ) + 64'(w_err) * 64'(KI);
        w_integ_sat  = INT_W'(sat_s(w_integ_wide, INT_W));
        w_integ_next = bus.freeze ? r_integ : w_integ_sat;
        // Proportional path stays live while the integrator is held
        w_fcw_sum    = c_sum_w'(NOM_FCW) + c_sum_w'(w_integ_next)
                     + c_sum_w'(w_err) * c_sum_w'(KP);
        w_fcw_next   = FCW_W'(clamp_u(64'(w_fcw_sum), FCW_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_integ <= '0;
            r_fcw   <= FCW_W'(NOM_FCW);
        end else begin
            r_integ <= w_integ_next;
            r_fcw   <= w_fcw_next;
        end
    end

    logic w_acc_msb;
    logic w_clk_out;

    pfd_dco #(
        .FCW_W (FCW_W),
        .ACC_W (ACC_W)
    ) u_dco (
        .clk     (clk),
        .rst     (rst),
        .fcw     (r_fcw),
        .acc_msb (w_acc_msb),
        .clk_out (w_clk_out)
    );

    // Lock detector
    logic                r_locked;
    logic [c_wcnt_w-1:0] r_width_cnt;
    logic [c_lcnt_w-1:0] r_lock_cnt;
    logic                w_pulse;
    logic [c_wcnt_w-1:0] w_width_next;
    logic                w_viol;
    logic                w_rise;

    always_comb begin
        w_pulse = r_qa_s | r_qb_s;
        if (!w_pulse)
            w_width_next = '0;
        else if (r_width_cnt == c_wmax)
            w_width_next = r_width_cnt;
        else
            w_width_next = r_width_cnt + c_wcnt_w'(1);
        w_viol = (w_width_next == c_wmax);
        // clk_out holds the previous accumulator MSB, so this marks a 0->1 step
        w_rise = w_acc_msb & ~w_clk_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_width_cnt <= '0;
            r_lock_cnt  <= '0;
            r_locked    <= 1'b0;
        end else begin
            r_width_cnt <= w_width_next;
            if (w_viol) begin
                r_lock_cnt <= '0;
                r_locked   <= 1'b0;
            end else begin
                if (w_rise && (r_lock_cnt != c_lmax))
                    r_lock_cnt <= r_lock_cnt + c_lcnt_w'(1);
                if (r_lock_cnt == c_lmax)
                    r_locked <= 1'b1;
            end
        end
    end

    assign bus.fcw     = r_fcw;
    assign bus.clk_out = w_clk_out;
    assign bus.locked  = r_locked;
endmodule
`default_nettype wire
